// File: rtl/unpooling_pkg.sv
// Shared helpers for the 2x2 nearest-neighbour unpooling block.
package unpooling_pkg;

  // Ceiling log2; callers guard against zero-width results.
  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  // True when the low n bits of value are all ones (n = 0 is vacuously true).
  function automatic logic low_ones(input logic [31:0] value, input int unsigned n);
    logic r;
    r = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < n && !value[i]) r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/unpooling_if.sv
// Pixel stream bundle: coarse input side and fine output side of the upsampler.
interface unpooling_if #(
  parameter int unsigned PIX_W  = 16,
  parameter int unsigned VCNT_W = 3,
  parameter int unsigned HCNT_W = 3
);
  logic              in_enable;
  logic [PIX_W-1:0]  in_pixels;
  logic [VCNT_W-1:0] in_vcnt;
  logic [HCNT_W-1:0] in_hcnt;
  logic              out_enable;
  logic [PIX_W-1:0]  out_pixels;
  logic [VCNT_W-1:0] out_vcnt;
  logic [HCNT_W-1:0] out_hcnt;

  modport master (
    output in_enable, in_pixels, in_vcnt, in_hcnt,
    input  out_enable, out_pixels, out_vcnt, out_hcnt
  );

  modport slave (
    input  in_enable, in_pixels, in_vcnt, in_hcnt,
    output out_enable, out_pixels, out_vcnt, out_hcnt
  );
endinterface

// File: rtl/unpool_line_buffer.sv
// Ping-pong coarse-row buffer: two banks, one write port, one registered read port.
module unpool_line_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2][DEPTH];

  // Storage array has no reset so it maps onto block RAM.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
  end

  // Read register only advances on valid fine samples, so it holds otherwise.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_bank][rd_addr];
    end
  end

endmodule

// File: rtl/unpooling.sv
// 2x2 nearest-neighbour upsampler: replicates level LEVEL+1 samples into
// 2x2 blocks at level LEVEL, one coarse row behind the input stream.
module unpooling
  import unpooling_pkg::*;
#(
  parameter int unsigned WIDTH      = 6,
  parameter int unsigned HEIGHT     = 6,
  parameter int unsigned W_WIDTH    = 8,
  parameter int unsigned W_HEIGHT   = 8,
  parameter int unsigned FIXED_BITW = 8,
  parameter int unsigned UNITS      = 2,
  parameter int unsigned LEVEL      = 0
) (
  input logic        clock,
  input logic        n_rst,
  unpooling_if.slave bus
);

  localparam int unsigned PIX_W  = FIXED_BITW * UNITS;
  localparam int unsigned VCNT_W = log2_ceil(W_HEIGHT);
  localparam int unsigned HCNT_W = log2_ceil(W_WIDTH);
  localparam int unsigned BLK    = 1 << (LEVEL + 1);
  localparam int unsigned DEPTH  = W_WIDTH >> (LEVEL + 1);
  localparam int unsigned ADDR_W = (DEPTH > 1) ? log2_ceil(DEPTH) : 1;

  logic              capture_c;
  logic              toggle_c;
  logic              fine_c;
  logic              out_en_c;
  logic [VCNT_W-1:0] vnext_c;
  logic [ADDR_W-1:0] addr_c;

  logic              wr_bank;
  logic              primed;
  logic              out_en_q;
  logic [VCNT_W-1:0] vcnt_q;
  logic [HCNT_W-1:0] hcnt_q;
  logic [PIX_W-1:0]  rd_data;

  // Grid decode, one-coarse-row coordinate offset and output qualification.
  always_comb begin
    capture_c = bus.in_enable
              && low_ones(32'(bus.in_hcnt), LEVEL + 1)
              && low_ones(32'(bus.in_vcnt), LEVEL + 1);
    toggle_c  = bus.in_enable
              && (32'(bus.in_hcnt) == W_WIDTH - 1)
              && low_ones(32'(bus.in_vcnt), LEVEL + 1);
    fine_c    = bus.in_enable
              && low_ones(32'(bus.in_hcnt), LEVEL)
              && low_ones(32'(bus.in_vcnt), LEVEL);
    if (32'(bus.in_vcnt) >= BLK) begin
      vnext_c = VCNT_W'(32'(bus.in_vcnt) - BLK);
    end else begin
      vnext_c = VCNT_W'(32'(bus.in_vcnt) + W_HEIGHT - BLK);
    end
    out_en_c  = fine_c && primed
              && (32'(vnext_c) < HEIGHT)
              && (32'(bus.in_hcnt) < WIDTH);
    addr_c    = ADDR_W'(32'(bus.in_hcnt) >> (LEVEL + 1));
  end

  // Bank/primed control and registered output coordinates.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      wr_bank  <= 1'b0;
      primed   <= 1'b0;
      out_en_q <= 1'b0;
      vcnt_q   <= '0;
      hcnt_q   <= '0;
    end else begin
      out_en_q <= out_en_c;
      if (bus.in_enable) begin
        vcnt_q <= vnext_c;
        hcnt_q <= bus.in_hcnt;
      end
      if (toggle_c) begin
        wr_bank <= ~wr_bank;
        primed  <= 1'b1;
      end
    end
  end

  unpool_line_buffer #(
    .DEPTH  (DEPTH),
    .DATA_W (PIX_W),
    .ADDR_W (ADDR_W)
  ) u_line_buffer (
    .clock   (clock),
    .n_rst   (n_rst),
    .wr_en   (capture_c),
    .wr_bank (wr_bank),
    .wr_addr (addr_c),
    .wr_data (bus.in_pixels),
    .rd_en   (out_en_c),
    .rd_bank (~wr_bank),
    .rd_addr (addr_c),
    .rd_data (rd_data)
  );

  assign bus.out_enable = out_en_q;
  assign bus.out_pixels = rd_data;
  assign bus.out_vcnt   = vcnt_q;
  assign bus.out_hcnt   = hcnt_q;

endmodule

// File: doc/unpooling.md
# unpooling

2x2 nearest-neighbour upsampler for the decoder side of the segmentation CNN. It is the inverse of the 2x2 max-pooling layer. It takes a sparse stream at pyramid level LEVEL+1, where only pixels whose low LEVEL+1 bits of both counters are all ones carry data. It emits a stream at level LEVEL, where each coarse sample is replicated into a 2x2 block of fine-grid samples. Rows are held in a ping-pong coarse-row buffer, so output coordinates lag input coordinates by exactly one coarse row.

## Interface
- WIDTH, -1, active image width in frame pixels
- HEIGHT, -1, active image height in frame lines
- W_WIDTH, -1, frame width including blanking; must be a multiple of 2^(LEVEL+1)
- W_HEIGHT, -1, frame height including blanking; must be a multiple of 2^(LEVEL+1) and > 2^(LEVEL+1)
- FIXED_BITW, -1, bits per channel value (signed fixed point, passed through unchanged)
- UNITS, -1, channels per pixel
- LEVEL, -1, output pyramid level (0 = every pixel valid); input level is LEVEL+1
- clock  in  1  single clock
- n_rst  in  1  reset, asynchronous, active-low
- in_enable  in  1  stream advance; when 0 the cycle is ignored
- in_pixels  in  [0:FIXED_BITW*UNITS-1]  coarse pixel, channel p at bits p*FIXED_BITW +: FIXED_BITW
- in_vcnt  in  log2(W_HEIGHT)  frame line counter
- in_hcnt  in  log2(W_WIDTH)  frame column counter
- out_enable  out  1  fine-grid sample valid
- out_pixels  out  [0:FIXED_BITW*UNITS-1]  upsampled pixel, same channel packing
- out_vcnt  out  log2(W_HEIGHT)  output line coordinate
- out_hcnt  out  log2(W_WIDTH)  output column coordinate

## Operation
- **Coarse capture:** a cycle captures when in_enable=1 and &in_hcnt[LEVEL:0] and &in_vcnt[LEVEL:0].
  - in_pixels is written to entry in_hcnt>>(LEVEL+1) of the write bank.
  - Buffer depth per bank is W_WIDTH>>(LEVEL+1).
- **Bank toggle:** wr_bank toggles on in_enable=1, in_hcnt==W_WIDTH-1 and &in_vcnt[LEVEL:0], i.e. at the last pixel of each coarse row.
  - A write in the same cycle still targets the old bank.
  - The read bank is always ~wr_bank.
- **Primed:** the primed flag sets at the first bank toggle after reset. Only reset clears it.
- **Output coordinates:** out_vcnt = (in_vcnt − 2^(LEVEL+1)) mod W_HEIGHT and out_hcnt = in_hcnt, both registered.
- **Fine grid:** a fine-grid cycle has in_enable=1 and, for LEVEL>0, &in_hcnt[LEVEL-1:0] and &in_vcnt[LEVEL-1:0]. For LEVEL=0 every enabled cycle is a fine-grid cycle.
- **out_enable** is the registered AND of four terms:
  - fine-grid cycle;
  - primed;
  - out_vcnt < HEIGHT;
  - in_hcnt < WIDTH.
- **Pixel data:** when out_enable=1, out_pixels = read_bank[in_hcnt>>(LEVEL+1)]. All four fine positions of a 2x2 block read the same entry. Otherwise out_pixels holds its previous value.
- **Channels:** no arithmetic is applied; UNITS channels share one buffer word.
- **in_enable=0:** no write, no toggle, out_enable=0 next cycle. Coordinate and pixel registers hold.
- **Reset (asynchronous, any time):**
  - out_enable=0, out_pixels=0, out_vcnt=0, out_hcnt=0;
  - wr_bank=0, primed=0.
  - Buffer contents need not be cleared; primed masks them.
- **Frame wrap:** the output of coarse row 0 appears while input is in coarse row 1. The last coarse row of frame N is output during the first coarse row of frame N+1, and is masked by the HEIGHT check if it lies in blanking.

## Timing
- Register latency is 1 cycle from input counters to output.
- Data lag is one coarse row: 2^(LEVEL+1)·W_WIDTH enabled cycles.
- The buffer read is combinational-address or 1-cycle-registered RAM. Either way, output data is aligned with the registered coordinates (out_enable at t+1 for a fine-grid cycle at t).
- Read and write never hit the same bank in one cycle. No bypass is needed.

## Structure
- **Shared package:**
  - log2 (ceil) function;
  - level-mask helper (all-ones test of the low n bits).
- **Sub-module unpool_line_buffer:**
  - two banks of depth W_WIDTH>>(LEVEL+1) × FIXED_BITW*UNITS;
  - one write port, one read port, bank-select inputs.
  - Infers block RAM.
- **Top:** capture/toggle/primed control, coordinate offset, output registers.

## Test plan
Common parameters: LEVEL=0, WIDTH=6, HEIGHT=6, W_WIDTH=8, W_HEIGHT=8, FIXED_BITW=8, UNITS=2, in_enable=1. Coarse pixel (r,c) is driven as {r*16+c, 8'hA0+c}.
- **First frame after reset:** no out_enable during input rows 0-1. At input row 2 col 0, out_vcnt=0, out_hcnt=0, out_pixels={8'h00,8'hA0} at t+1.
- **2x2 replication:** fine outputs (2,4),(2,5),(3,4),(3,5) all equal coarse (1,2) = {8'h12,8'hA2}. out_enable is high on all four.
- **Blanking:** out_enable=0 at out_hcnt 6,7 and out_vcnt 6,7. At frame wrap, input rows 0-1 output rows 6-7, all masked.
- **in_enable stall:** deassert for 5 cycles mid-row. Outputs hold, out_enable=0. On resume, the sequence continues with no skipped or duplicated fine samples.
- **Mid-row reset:** pulse n_rst low mid-row 3. All outputs go to 0 immediately, and out_enable stays 0 until one full coarse row has completed.
- **LEVEL=1 (W_WIDTH=16):**
  - out_enable only where out_hcnt[0] and out_vcnt[0] are 1;
  - the value changes every 4 columns;
  - data lags by 4 lines.
